// File: rtl/alu_sequencer.sv
// Three-state (IDLE/EXEC/WB) instruction sequencer driving an external combinational
// ALU over an 8-entry register file. Define ALU_SEQ_ZERO_FLAG_EN to add the zero_flag output.
module alu_sequencer #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        instr_func,
  input  logic [2:0]        instr_rd,
  input  logic [2:0]        instr_ra,
  input  logic [2:0]        instr_rb,
  input  logic [DATA_W-1:0] instr_imm,
  output logic [DATA_W-1:0] alu_op1,
  output logic [DATA_W-1:0] alu_op2,
  output logic [2:0]        alu_func,
  input  logic [DATA_W-1:0] alu_result,
  output logic              done,
  input  logic [2:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
`ifdef ALU_SEQ_ZERO_FLAG_EN
  ,
  output logic              zero_flag
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_e;

  localparam logic [2:0] FUNC_LI = 3'b111;

  state_e            state_q, state_d;
  logic              accept, exec_end, wb_end, rf_we;

  logic [DATA_W-1:0] rf_q [8];
  logic [DATA_W-1:0] rf_a, rf_b;

  logic [DATA_W-1:0] op1_q, op1_d;
  logic [DATA_W-1:0] op2_q, op2_d;
  logic [2:0]        func_q, func_d;
  logic [2:0]        rd_q, rd_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              done_q, done_d;

  // r0 is hardwired to zero on every read path.
  assign rf_a     = (instr_ra == 3'd0) ? '0 : rf_q[instr_ra];
  assign rf_b     = (instr_rb == 3'd0) ? '0 : rf_q[instr_rb];
  assign dbg_data = (dbg_addr == 3'd0) ? '0 : rf_q[dbg_addr];

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_d     = state_q;
    instr_ready = 1'b0;
    accept      = 1'b0;
    exec_end    = 1'b0;
    wb_end      = 1'b0;
    case (state_q)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          accept  = 1'b1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        exec_end = 1'b1;
        state_d  = S_WB;
      end
      S_WB: begin
        wb_end  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    op1_d    = op1_q;
    op2_d    = op2_q;
    func_d   = func_q;
    rd_d     = rd_q;
    imm_d    = imm_q;
    result_d = result_q;
    done_d   = wb_end;
    if (accept) begin
      op1_d  = rf_a;
      op2_d  = rf_b;
      func_d = instr_func;
      rd_d   = instr_rd;
      imm_d  = instr_imm;
    end
    // LI bypasses the ALU; every other code, defined or not, takes the ALU's answer.
    if (exec_end) begin
      result_d = (func_q == FUNC_LI) ? imm_q : alu_result;
    end
  end

  assign rf_we = wb_end && (rd_q != 3'd0);

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op1_q    <= '0;
      op2_q    <= '0;
      func_q   <= '0;
      rd_q     <= '0;
      imm_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      // NOTE: the register file is architecturally cleared by reset, so it is flops, not a RAM.
      for (int i = 0; i < 8; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      func_q   <= func_d;
      rd_q     <= rd_d;
      imm_q    <= imm_d;
      result_q <= result_d;
      done_q   <= done_d;
      if (rf_we) begin
        rf_q[rd_q] <= result_q;
      end
    end
  end

  assign alu_op1  = op1_q;
  assign alu_op2  = op2_q;
  assign alu_func = func_q;
  assign done     = done_q;

`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic zero_q, zero_d;

  // A write aimed at r0 stores 0, so it reports zero regardless of the result.
  assign zero_d = wb_end ? (!rf_we || (result_q == '0)) : zero_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
    end else begin
      zero_q <= zero_d;
    end
  end

  assign zero_flag = zero_q;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: stimulus pushes predicted write-backs from an
// ISA-level model; a monitor pops and compares on each done pulse.
module tb_alu_sequencer;

  localparam int W   = 4;
  localparam int MOD = 1 << W;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         instr_valid;
  logic         instr_ready;
  logic [2:0]   instr_func, instr_rd, instr_ra, instr_rb;
  logic [W-1:0] instr_imm;
  logic [W-1:0] alu_op1, alu_op2, alu_result;
  logic [2:0]   alu_func;
  logic         done;
  logic [2:0]   dbg_addr;
  logic [W-1:0] dbg_data;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic         zero_flag;
`endif

  alu_sequencer #(.DATA_W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_func  (instr_func),
    .instr_rd    (instr_rd),
    .instr_ra    (instr_ra),
    .instr_rb    (instr_rb),
    .instr_imm   (instr_imm),
    .alu_op1     (alu_op1),
    .alu_op2     (alu_op2),
    .alu_func    (alu_func),
    .alu_result  (alu_result),
    .done        (done),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
`ifdef ALU_SEQ_ZERO_FLAG_EN
    ,
    .zero_flag   (zero_flag)
`endif
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // External team ALU; LI returns deliberate garbage that the sequencer must ignore.
  always_comb begin
    case (alu_func)
      3'd0:    alu_result = alu_op1 + alu_op2;
      3'd1:    alu_result = alu_op1 - alu_op2;
      3'd2:    alu_result = alu_op1 & alu_op2;
      3'd3:    alu_result = alu_op1 | alu_op2;
      3'd4:    alu_result = (alu_op1 < alu_op2) ? W'(1) : W'(0);
      3'd7:    alu_result = ~(alu_op1 ^ alu_op2) ^ W'(5);
      default: alu_result = '0;
    endcase
  end

  typedef struct {
    logic [2:0]   rd;
    logic [W-1:0] val;
    int unsigned  acc;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] model_rf [8];
  int           checks = 0;
  int           errors = 0;
  int           done_seen = 0;

  logic         mon_sel = 1'b0;
  logic [2:0]   mon_addr = '0;
  logic [2:0]   stim_addr = '0;
  assign dbg_addr = mon_sel ? mon_addr : stim_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned ref_exec(input logic [2:0] f, input int unsigned a,
                                           input int unsigned b, input int unsigned imm);
    case (f)
      3'd0:    return (a + b) % MOD;
      3'd1:    return (a + MOD - b) % MOD;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return (a < b) ? 1 : 0;
      3'd7:    return imm;
      default: return 0;
    endcase
  endfunction

  // Waits for ready (driving ignored junk meanwhile), offers one instruction, and
  // records its predicted write-back. With hold set, valid stays high afterwards.
  task automatic issue(input logic [2:0] f, input logic [2:0] d, input logic [2:0] a,
                       input logic [2:0] b, input logic [W-1:0] imm, input bit hold,
                       output int unsigned acc);
    int          budget = 16;
    int unsigned v;
    exp_t        e;
    while (!instr_ready && budget > 0) begin
      instr_valid = hold ? 1'b1 : 1'($urandom_range(0, 1));
      instr_func  = 3'($urandom);
      instr_rd    = 3'($urandom);
      instr_ra    = 3'($urandom);
      instr_rb    = 3'($urandom);
      instr_imm   = W'($urandom);
      @(negedge clk);
      budget--;
    end
    check("ready_within_budget", instr_ready, 1);
    instr_valid = 1'b1;
    instr_func  = f;
    instr_rd    = d;
    instr_ra    = a;
    instr_rb    = b;
    instr_imm   = imm;
    v = ref_exec(f, model_rf[a], model_rf[b], imm);
    if (d != 3'd0) model_rf[d] = W'(v);
    e.rd  = d;
    e.val = (d == 3'd0) ? W'(0) : W'(v);
    e.acc = cyc + 1;
    acc   = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    instr_valid = hold;
    instr_func  = 3'($urandom);
    instr_rd    = 3'($urandom);
    instr_ra    = 3'($urandom);
    instr_rb    = 3'($urandom);
  endtask

  task automatic drain();
    int budget = 40;
    instr_valid = 1'b0;
    while (sb.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("drain_sb_empty", sb.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic read_reg(input string name, input logic [2:0] a, input logic [W-1:0] exp);
    @(negedge clk);
    stim_addr = a;
    #1;
    check(name, dbg_data, exp);
  endtask

  task automatic sweep_model(input string name);
    for (int i = 0; i < 8; i++) begin
      read_reg(name, 3'(i), model_rf[i]);
    end
  endtask

  // Monitor: every done pulse retires the oldest outstanding instruction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        done_seen++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 with nothing outstanding, expected done=0 (t=%0t)", $time);
        end else begin
          e = sb.pop_front();
          check("done_latency", cyc, e.acc + 2);
          mon_addr = e.rd;
          mon_sel  = 1'b1;
          #1;
          check("wb_value", dbg_data, e.val);
`ifdef ALU_SEQ_ZERO_FLAG_EN
          check("zero_flag", zero_flag, (e.val == '0));
`endif
          mon_sel = 1'b0;
          @(negedge clk);
          check("done_single_cycle", done, 0);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned acc [5];
    int unsigned a0;
    int          done_before;
    bit          hold;
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr_func  = '0;
    instr_rd    = '0;
    instr_ra    = '0;
    instr_rb    = '0;
    instr_imm   = '0;
    for (int i = 0; i < 8; i++) model_rf[i] = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state.
    check("reset_ready", instr_ready, 1);
    check("reset_done", done, 0);
    check("reset_op1", alu_op1, 0);
    check("reset_func", alu_func, 0);
`ifdef ALU_SEQ_ZERO_FLAG_EN
    check("reset_zero_flag", zero_flag, 0);
`endif
    for (int i = 0; i < 8; i++) read_reg("reset_rf", 3'(i), '0);

    // LI, LI, ADD.
    done_before = done_seen;
    issue(3'd7, 3'd1, 3'd0, 3'd0, 4'd5, 1'b0, a0);
    issue(3'd7, 3'd2, 3'd0, 3'd0, 4'd3, 1'b0, a0);
    issue(3'd0, 3'd3, 3'd1, 3'd2, 4'd0, 1'b0, a0);
    drain();
    check("three_done_pulses", done_seen - done_before, 3);
    read_reg("add_r3", 3'd3, 4'd8);
    check("held_op1", alu_op1, 5);
    check("held_op2", alu_op2, 3);
    check("held_func", alu_func, 0);

    // SUB wrap, SLT, AND, OR.
    issue(3'd1, 3'd4, 3'd2, 3'd1, 4'd0, 1'b0, a0);
    issue(3'd4, 3'd5, 3'd2, 3'd1, 4'd0, 1'b0, a0);
    issue(3'd2, 3'd6, 3'd2, 3'd1, 4'd0, 1'b0, a0);
    issue(3'd3, 3'd7, 3'd2, 3'd1, 4'd0, 1'b0, a0);
    drain();
    read_reg("sub_wrap_r4", 3'd4, 4'd14);
    read_reg("slt_r5", 3'd5, 4'd1);
    read_reg("and_r6", 3'd6, 4'd1);
    read_reg("or_r7", 3'd7, 4'd7);

    // Back-to-back dependent ADDs with valid held high.
    issue(3'd7, 3'd1, 3'd0, 3'd0, 4'd1, 1'b1, acc[0]);
    for (int i = 1; i < 5; i++) begin
      issue(3'd0, 3'd1, 3'd1, 3'd1, 4'd0, (i != 4), acc[i]);
    end
    for (int i = 1; i < 5; i++) check("accept_spacing", acc[i] - acc[i-1], 3);
    drain();
    read_reg("chain_r1", 3'd1, 4'd0);

    // LI to r0 is discarded.
    issue(3'd7, 3'd0, 3'd0, 3'd0, 4'd9, 1'b0, a0);
    drain();
    read_reg("li_r0", 3'd0, 4'd0);
`ifdef ALU_SEQ_ZERO_FLAG_EN
    check("li_r0_zero_flag", zero_flag, 1);
`endif

    // Randomized traffic, including undefined codes and chained issue.
    hold = 1'b0;
    for (int n = 0; n < 80; n++) begin
      hold = (n != 79) && ($urandom_range(0, 2) == 0);
      issue(3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), W'($urandom), hold, a0);
    end
    drain();
    sweep_model("random_rf");

    // Reset during EXEC aborts the instruction.
    done_before = done_seen;
    instr_valid = 1'b1;
    instr_func  = 3'd7;
    instr_rd    = 3'd2;
    instr_ra    = 3'd0;
    instr_rb    = 3'd0;
    instr_imm   = 4'd7;
    @(negedge clk);
    check("abort_in_exec", instr_ready, 0);
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    #1;
    check("abort_idle", instr_ready, 1);
    check("abort_done_low", done, 0);
    check("abort_func_cleared", alu_func, 0);
    for (int i = 0; i < 8; i++) model_rf[i] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("abort_no_done", done_seen - done_before, 0);
    check("abort_ready_after", instr_ready, 1);
    read_reg("abort_r2", 3'd2, 4'd0);
    sweep_model("post_abort_rf");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 4, operand/register width; the sequencer is only required to work at 4.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port instr_valid  input  1  instruction offered.
REQ-005 SHALL have port instr_ready  output  1  sequencer can accept an instruction.
REQ-006 SHALL have port instr_func  input  3  operation: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT, 111 LI (load immediate), 101/110 undefined.
REQ-007 SHALL have port instr_rd  input  3  destination register index.
REQ-008 SHALL have port instr_ra  input  3  source A register index.
REQ-009 SHALL have port instr_rb  input  3  source B register index.
REQ-010 SHALL have port instr_imm  input  DATA_W  immediate value for LI.
REQ-011 SHALL have port alu_op1  output  DATA_W  operand 1 to the external ALU.
REQ-012 SHALL have port alu_op2  output  DATA_W  operand 2 to the external ALU.
REQ-013 SHALL have port alu_func  output  3  function code to the external ALU.
REQ-014 SHALL have port alu_result  input  DATA_W  combinational result from the external ALU.
REQ-015 SHALL have port done  output  1  one-cycle pulse: instruction retired.
REQ-016 SHALL have port dbg_addr  input  3  debug read index.
REQ-017 SHALL have port dbg_data  output  DATA_W  combinational read of register dbg_addr.

Function
REQ-018 SHALL contain 8 registers of DATA_W bits; r0 SHALL always read 0, and writes to r0 SHALL be discarded.
REQ-019 SHALL implement a three-state FSM: IDLE, EXEC, WB.
REQ-020 instr_ready SHALL be 1 only in IDLE; an instruction is accepted on an edge where instr_valid and instr_ready are both 1.
REQ-021 On accept, SHALL latch rf[ra] into alu_op1, rf[rb] into alu_op2, func into alu_func, and rd and imm internally; SHALL then go IDLE->EXEC.
REQ-022 At the end of EXEC, SHALL capture alu_result (or the latched imm when func=111) into a result register; SHALL then go EXEC->WB.
REQ-023 At the end of WB, SHALL write the result register to rf[rd], assert done for the following cycle only, and go WB->IDLE.
REQ-024 Latency: accept at edge N, register write at edge N+2, done high during cycle N+2..N+3; peak throughput is one instruction per 3 cycles.
REQ-025 An instruction accepted in the same cycle done is high SHALL read the just-written value (no hazard).
REQ-026 alu_op1, alu_op2 and alu_func SHALL hold their values outside EXEC until the next accept.
REQ-027 func 101/110 SHALL be passed to the ALU unchanged, and whatever the ALU returns SHALL be written (the team ALU returns 0 for these codes).
REQ-028 ra, rb and rd may be equal; operands SHALL use pre-write values.
REQ-029 Instruction inputs SHALL be ignored while instr_ready=0.

Reset
REQ-030 rst_n=0 SHALL immediately force the FSM to IDLE, clear all registers, clear alu_op1, alu_op2, alu_func, done and the result register to 0, and drive instr_ready to 1 after release.
REQ-031 Reset asserted mid-instruction SHALL abort it with no register write and no done pulse.

Configuration
REQ-032 With macro ALU_SEQ_ZERO_FLAG_EN defined, SHALL add port zero_flag  output  1, reset to 0 and updated at each WB edge to (written value == 0), including writes to r0 (value 0 → 1).
REQ-033 Without ALU_SEQ_ZERO_FLAG_EN, the zero_flag port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-034 Reset then dbg_addr sweep 0..7 -> dbg_data=0 for all; instr_ready=1, done=0.
REQ-035 LI r1=5, LI r2=3, ADD r3=r1+r2 -> rf[3]=8; done pulses 3 times; each write occurs 2 edges after its accept.
REQ-036 With r1=5, r2=3: SUB r4=r2-r1 -> rf[4]=14 (4-bit wrap); SLT r5=r2<r1 -> rf[5]=1; AND r6 -> 1; OR r7 -> 7.
REQ-037 instr_valid held high continuously with back-to-back dependent ADDs r1=r1+r1 starting from r1=1 -> rf[1]=2,4,8,0; accepts exactly every 3 cycles.
REQ-038 LI r0=9 -> dbg_data(r0)=0; with ALU_SEQ_ZERO_FLAG_EN, zero_flag=1.
REQ-039 Assert rst_n=0 during EXEC of LI r2=7 -> rf[2]=0, no done pulse, FSM in IDLE.
